rbm_gibbs_engine: RTL

- Parametrised, sequential successor to the flat RBM inference path.
- Takes a binary visible vector and runs N Gibbs samples. Each sample computes hidden pre-activations, applies a hard sigmoid, draws binary hidden units with per-unit LFSRs, then scores classes.
- Class scores are accumulated over the N samples; the block reports the accumulated scores and the argmax class.
- Sits between image/weight storage and the classification readout; it replaces free-running iteration with a start/done handshake.

---
 rtl/rbm_gibbs_engine_pkg.sv | 50 +++++
 rtl/rbm_lfsr16.sv | 38 +++
 rtl/rbm_gibbs_engine.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rbm_gibbs_engine_pkg.sv
// ----------------------------------------------------------------------------
// rbm_gibbs_engine_pkg
// Shared definitions for the RBM Gibbs-sampling engine:
//   - RBM_PORT_1D / RBM_PORT_2D : slice one element out of a flattened bus
//   - LFSR_TAPS / LFSR_ZERO_SEED : 16-bit Galois LFSR constants
//   - state encodings and the state_t enum used by the engine FSM
//   - clog2 : constant-evaluable ceil(log2()) helper for width derivation
// No ports (package).
// ----------------------------------------------------------------------------
`ifndef RBM_GIBBS_ENGINE_PKG_SV
`define RBM_GIBBS_ENGINE_PKG_SV

// Element idx of a 1-D flattened bus with element width w.
`define RBM_PORT_1D(bus, idx, w) bus[(idx)*(w) +: (w)]
// Element (r,c) of a row-major 2-D flattened bus with ncol columns.
`define RBM_PORT_2D(bus, r, c, ncol, w) bus[((r)*(ncol)+(c))*(w) +: (w)]

package rbm_gibbs_engine_pkg;

    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    // An all-zero Galois LFSR never leaves zero, so a zero seed is swapped.
    localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_HID    = 3'd1;
    localparam logic [2:0] ENC_SAMPLE = 3'd2;
    localparam logic [2:0] ENC_CLS    = 3'd3;
    localparam logic [2:0] ENC_ACC    = 3'd4;
    localparam logic [2:0] ENC_DONE   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_HID    = ENC_HID,
        ST_SAMPLE = ENC_SAMPLE,
        ST_CLS    = ENC_CLS,
        ST_ACC    = ENC_ACC,
        ST_DONE   = ENC_DONE
    } state_t;

    // Smallest r with 2**r >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

`endif

// File: rtl/rbm_lfsr16.sv
// ----------------------------------------------------------------------------
// rbm_lfsr16
// 16-bit right-shifting Galois LFSR used as the random source for one hidden
// unit. A zero seed is replaced on load so the register cannot lock up.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset, clears the register to 0
//   load   in   load seed (has priority over step)
//   seed   in   [15:0] seed value
//   step   in   advance the sequence by one state
//   q      out  [15:0] current LFSR state
// ----------------------------------------------------------------------------
module rbm_lfsr16
    import rbm_gibbs_engine_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= (seed == 16'h0000) ? LFSR_ZERO_SEED : seed;
        end else if (step) begin
            r_q <= (r_q >> 1) ^ (r_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/rbm_gibbs_engine.sv
// ----------------------------------------------------------------------------
// rbm_gibbs_engine
// Sequential RBM inference: latches a binary visible vector, then runs
// max(n_samples,1) Gibbs samples. Each sample accumulates hidden
// pre-activations one visible bit per cycle, applies a hard sigmoid, draws
// binary hidden units (threshold or per-unit LFSR), scores every class one
// hidden unit per cycle and adds the class scores into saturating
// accumulators. Results and the argmax class are published with a done pulse.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   start      in   begin a run (only looked at in IDLE)
//   abort      in   cancel the run in progress
//   mode_det   in   1 = deterministic threshold, 0 = stochastic draw
//   n_samples  in   [CNT_W] number of samples, 0 treated as 1
//   image      in   [IN_DIM] binary visible vector
//   seeds      in   [H_DIM*16] per-hidden-unit LFSR seeds
//   h_weight   in   [IN_DIM*H_DIM*IN_W] visible->hidden weights, (i,j) row-major
//   h_bias     in   [H_DIM*IN_W] hidden biases
//   c_weight   in   [H_DIM*OUT_DIM*IN_W] hidden->class weights, (j,k) row-major
//   c_bias     in   [OUT_DIM*IN_W] class biases
//   busy       out  run in progress
//   done       out  one-cycle pulse, result/class_out just updated
//   result     out  [OUT_DIM*OUT_W] accumulated class scores
//   class_out  out  [CLS_W] index of the largest score, lowest index on ties
// Weight and bias buses are read directly and must be held while busy.
// FRAC+2 must be >= SIG_W so the sigmoid shift is non-negative.
// ----------------------------------------------------------------------------
module rbm_gibbs_engine
    import rbm_gibbs_engine_pkg::*;
#(
    parameter  int IN_DIM  = 15,
    parameter  int H_DIM   = 5,
    parameter  int OUT_DIM = 2,
    parameter  int IN_W    = 12,
    parameter  int FRAC    = 8,
    parameter  int SIG_W   = 8,
    parameter  int OUT_W   = 12,
    parameter  int CNT_W   = 8,
    localparam int CLS_W   = (clog2(OUT_DIM) > 0) ? clog2(OUT_DIM) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           mode_det,
    input  logic [CNT_W-1:0]               n_samples,
    input  logic [IN_DIM-1:0]              image,
    input  logic [H_DIM*16-1:0]            seeds,
    input  logic [IN_DIM*H_DIM*IN_W-1:0]   h_weight,
    input  logic [H_DIM*IN_W-1:0]          h_bias,
    input  logic [H_DIM*OUT_DIM*IN_W-1:0]  c_weight,
    input  logic [OUT_DIM*IN_W-1:0]        c_bias,
    output logic                           busy,
    output logic                           done,
    output logic [OUT_DIM*OUT_W-1:0]       result,
    output logic [CLS_W-1:0]               class_out
);

    // Hidden accumulator holds bias plus up to IN_DIM weights without overflow;
    // the per-sample class accumulator likewise for H_DIM weights.
    localparam int HACC_W = IN_W + clog2(IN_DIM + 1);
    localparam int CACC_W = IN_W + clog2(H_DIM + 1);
    localparam int SUM_W  = ((OUT_W > CACC_W) ? OUT_W : CACC_W) + 1;
    localparam int SHIFT  = FRAC + 2 - SIG_W;
    localparam int SIG_TW = HACC_W + SIG_W + 1;
    localparam int I_W    = (clog2(IN_DIM) > 0) ? clog2(IN_DIM) : 1;
    localparam int J_W    = (clog2(H_DIM) > 0) ? clog2(H_DIM) : 1;

    localparam logic [I_W-1:0]           LAST_I     = I_W'(IN_DIM - 1);
    localparam logic [J_W-1:0]           LAST_J     = J_W'(H_DIM - 1);
    localparam logic signed [SIG_TW-1:0] SIG_ZERO   = '0;
    localparam logic signed [SIG_TW-1:0] SIG_HALF   = SIG_TW'(2**(SIG_W-1));
    localparam logic signed [SIG_TW-1:0] SIG_MAXV   = SIG_TW'(2**SIG_W - 1);
    localparam logic [SIG_W-1:0]         SIG_HALF_U = SIG_W'(2**(SIG_W-1));
    localparam logic [15:0]              SIG_MASK16 = 16'(2**SIG_W - 1);
    localparam logic signed [SUM_W-1:0]  SUM_MAX    = SUM_W'(2**(OUT_W-1) - 1);
    localparam logic signed [SUM_W-1:0]  SUM_MIN    = SUM_W'(-(2**(OUT_W-1)));

    // Hard sigmoid: rescale to SIG_W fractional bits, recentre on one half,
    // clamp to the unsigned probability range.
    function automatic logic [SIG_W-1:0] hard_sigmoid(input logic signed [HACC_W-1:0] a);
        logic signed [SIG_TW-1:0] t;
        t = SIG_TW'(a >>> SHIFT) + SIG_HALF;
        if (t < SIG_ZERO)
            hard_sigmoid = '0;
        else if (t > SIG_MAXV)
            hard_sigmoid = '1;
        else
            hard_sigmoid = t[SIG_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] v);
        if (v > SUM_MAX)
            sat_out = SUM_MAX[OUT_W-1:0];
        else if (v < SUM_MIN)
            sat_out = SUM_MIN[OUT_W-1:0];
        else
            sat_out = v[OUT_W-1:0];
    endfunction

    state_t                   r_state;
    logic                     r_busy;
    logic                     r_done;
    logic [OUT_DIM*OUT_W-1:0] r_result;
    logic [CLS_W-1:0]         r_class;
    logic [IN_DIM-1:0]        r_image;
    logic                     r_mode_det;
    logic [CNT_W-1:0]         r_last;
    logic [CNT_W-1:0]         r_s;
    logic [I_W-1:0]           r_i;
    logic [J_W-1:0]           r_j;
    logic [H_DIM-1:0]         r_h;
    logic signed [HACC_W-1:0] r_hacc [H_DIM];
    logic signed [CACC_W-1:0] r_cacc [OUT_DIM];
    logic signed [OUT_W-1:0]  r_sacc [OUT_DIM];

    logic signed [HACC_W-1:0] w_hbias     [H_DIM];
    logic signed [HACC_W-1:0] w_hsum      [H_DIM];
    logic [SIG_W-1:0]         w_sig       [H_DIM];
    logic [H_DIM-1:0]         w_h_draw;
    logic [15:0]              w_lfsr      [H_DIM];
    logic signed [CACC_W-1:0] w_cbias     [OUT_DIM];
    logic signed [CACC_W-1:0] w_csum      [OUT_DIM];
    logic signed [OUT_W-1:0]  w_sacc_next [OUT_DIM];
    logic signed [OUT_W-1:0]  w_best_val;
    logic [CLS_W-1:0]         w_best_idx;
    logic                     w_lfsr_load;
    logic                     w_lfsr_step;

    assign w_lfsr_load = (r_state == ST_IDLE) && start && !abort;
    assign w_lfsr_step = (r_state == ST_SAMPLE);

    for (genvar g = 0; g < H_DIM; g++) begin : g_lfsr
        rbm_lfsr16 u_lfsr (
            .clock (clock),
            .reset (reset),
            .load  (w_lfsr_load),
            .seed  (`RBM_PORT_1D(seeds, g, 16)),
            .step  (w_lfsr_step),
            .q     (w_lfsr[g])
        );
    end

    // Hidden path: bias, next accumulator value for the current visible bit,
    // sigmoid and draw of the value accumulated so far.
    always_comb begin
        for (int j = 0; j < H_DIM; j++) begin
            w_hbias[j] = HACC_W'(signed'(`RBM_PORT_1D(h_bias, j, IN_W)));
            w_hsum[j]  = r_hacc[j];
            if (r_image[r_i])
                w_hsum[j] = r_hacc[j]
                          + HACC_W'(signed'(`RBM_PORT_2D(h_weight, int'(r_i), j, H_DIM, IN_W)));
            w_sig[j] = hard_sigmoid(r_hacc[j]);
            if (r_mode_det)
                w_h_draw[j] = (w_sig[j] >= SIG_HALF_U);
            else
                w_h_draw[j] = ((w_lfsr[j] & SIG_MASK16) < 16'(w_sig[j]));
        end
    end

    // Class path: per-sample score step and the saturating sample accumulation.
    always_comb begin
        for (int k = 0; k < OUT_DIM; k++) begin
            w_cbias[k] = CACC_W'(signed'(`RBM_PORT_1D(c_bias, k, IN_W)));
            w_csum[k]  = r_cacc[k];
            if (r_h[r_j])
                w_csum[k] = r_cacc[k]
                          + CACC_W'(signed'(`RBM_PORT_2D(c_weight, int'(r_j), k, OUT_DIM, IN_W)));
            w_sacc_next[k] = sat_out(SUM_W'(r_sacc[k]) + SUM_W'(r_cacc[k]));
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        w_best_idx = '0;
        w_best_val = r_sacc[0];
        for (int k = 1; k < OUT_DIM; k++) begin
            if (r_sacc[k] > w_best_val) begin
                w_best_val = r_sacc[k];
                w_best_idx = CLS_W'(k);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_class    <= '0;
            r_image    <= '0;
            r_mode_det <= 1'b0;
            r_last     <= '0;
            r_s        <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_h        <= '0;
            for (int j = 0; j < H_DIM; j++) r_hacc[j] <= '0;
            for (int k = 0; k < OUT_DIM; k++) begin
                r_cacc[k] <= '0;
                r_sacc[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            // Abort wins over every state transition, including DONE.
            if (abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_image    <= image;
                            r_mode_det <= mode_det;
                            r_last     <= (n_samples == '0) ? '0 : n_samples - 1'b1;
                            r_s        <= '0;
                            r_i        <= '0;
                            for (int j = 0; j < H_DIM; j++) r_hacc[j] <= w_hbias[j];
                            for (int k = 0; k < OUT_DIM; k++) r_sacc[k] <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_HID;
                        end
                    end
                    ST_HID: begin
                        for (int j = 0; j < H_DIM; j++) r_hacc[j] <= w_hsum[j];
                        if (r_i == LAST_I) begin
                            r_i     <= '0;
                            r_state <= ST_SAMPLE;
                        end else begin
                            r_i <= r_i + 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        r_h <= w_h_draw;
                        for (int k = 0; k < OUT_DIM; k++) r_cacc[k] <= w_cbias[k];
                        r_j     <= '0;
                        r_state <= ST_CLS;
                    end
                    ST_CLS: begin
                        for (int k = 0; k < OUT_DIM; k++) r_cacc[k] <= w_csum[k];
                        if (r_j == LAST_J) begin
                            r_state <= ST_ACC;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end
                    ST_ACC: begin
                        for (int k = 0; k < OUT_DIM; k++) r_sacc[k] <= w_sacc_next[k];
                        if (r_s == r_last) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_s     <= r_s + 1'b1;
                            r_i     <= '0;
                            for (int j = 0; j < H_DIM; j++) r_hacc[j] <= w_hbias[j];
                            r_state <= ST_HID;
                        end
                    end
                    ST_DONE: begin
                        for (int k = 0; k < OUT_DIM; k++)
                            r_result[k*OUT_W +: OUT_W] <= r_sacc[k];
                        r_class <= w_best_idx;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign class_out = r_class;

endmodule
